charge_bay_scheduler: RTL and testbench
=======================================

# charge_bay_scheduler

Time-slicing scheduler that shares the station's single charge counter among `NUM_BAYS` vehicle bays. It picks requesting bays in round-robin order and decodes the granted bay's mode into a counter rate. It drives `CounterEnable`/`CounterInput` for one slice, then releases and re-arbitrates. It sits between the per-bay plug/mode logic and the charge counter, replacing direct single-bay drive of the counter.

## Interface
- `NUM_BAYS`, 4, number of bays (2..8)
- `SLICE_CYCLES`, 16, max consecutive charging cycles per grant (2..4095)
- `Clock`  in  1  rising-edge clock
- `ResetN`  in  1  asynchronous, active-low reset
- `BayRequest`  in  NUM_BAYS  bay b wants charge (level)
- `BayMode`  in  4*NUM_BAYS  mode of bay b in bits [4b+3:4b]
- `BayDone`  in  NUM_BAYS  bay b battery full / unplugged (level)
- `Grant`  out  NUM_BAYS  one-hot granted bay, registered
- `ActiveBay`  out  3  index of granted bay, valid while `Grant` != 0
- `CounterEnable`  out  1  charge counter enable
- `CounterInput`  out  4  counter rate per cycle
- `ModeError`  out  NUM_BAYS  one-cycle pulse: bay skipped for invalid mode

## Operation
- Eligible bay: `BayRequest[b]=1` and `BayDone[b]=0`.
- Mode decode:
  - 4'b0010 normal → rate 1.
  - 4'b1010 fast → rate 5.
  - Any other mode is invalid.
- FSM states:
  - IDLE: all outputs 0. If any eligible bay exists, select the first eligible bay at or after `RrPtr` (wrap at NUM_BAYS-1 → 0).
    - Valid mode: latch bay and rate → GRANT.
    - Invalid mode: pulse `ModeError[b]`, set `RrPtr=b+1` (wrapped), stay IDLE.
  - GRANT (1 cycle): `Grant` set, `CounterEnable=0`, `SliceCnt` cleared → CHARGE.
  - CHARGE: `CounterEnable=1`, `CounterInput`=latched rate, `SliceCnt++` each cycle. Exit to RELEASE when any of:
    - `SliceCnt==SLICE_CYCLES-1`,
    - granted bay's `BayRequest` falls,
    - granted bay's `BayDone` rises.
  - RELEASE (1 cycle): `Grant=0`, `CounterEnable=0`, `CounterInput=0`, `RrPtr=granted+1` (wrapped) → IDLE.
- Mode is sampled only at selection. A mode change mid-slice takes effect at the next grant.
- Requests from non-granted bays never pre-empt an active slice.
- Single eligible bay: it is regranted back-to-back. Each slice costs `SLICE_CYCLES` + 3 cycles (IDLE, GRANT, RELEASE).
- `SliceCnt` width is 12 bits. Saturation is not needed because exit occurs at `SLICE_CYCLES-1`.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, `RrPtr=0`.
  - `Grant`, `ActiveBay`, `CounterEnable`, `CounterInput`, `ModeError`, `SliceCnt` all 0.
- Request to `Grant` latency: 1 cycle (IDLE sample → GRANT).
- Request to `CounterEnable` latency: 2 cycles.
- `CounterEnable` stays high for exactly `SLICE_CYCLES` cycles unless terminated early.
- Early-exit latency: condition sampled in cycle n → `CounterEnable=0` in cycle n+1.
- Reset asserted mid-CHARGE: outputs clear immediately (asynchronously), and the partial slice is discarded.
- `ModeError` is high for exactly one cycle per skip. The same bay can re-error on its next turn.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- `CHARGE_FAST_PRIORITY_EN` defined:
  - In IDLE, eligible bays with fast mode are selected ahead of normal bays.
  - Round-robin applies within each class, using a shared `RrPtr`.
  - A normal bay is still granted once no fast bay is eligible.
- Undefined: pure round-robin, with mode ignored for ordering.

## Structure
- Package `charge_pkg`:
  - state enum {IDLE, GRANT, CHARGE, RELEASE},
  - `MODE_NORMAL=4'b0010`, `MODE_FAST=4'b1010`,
  - `RATE_NORMAL=4'd1`, `RATE_FAST=4'd5`,
  - mode→rate decode function.
- Sub-module `rr_picker`: combinational round-robin priority encoder.
  - Inputs: `Eligible` vector, `RrPtr`.
  - Outputs: one-hot pick, index, any-valid.
  - With the macro, it is instantiated twice (fast and all), and the fast result wins.

## Test plan
- Reset, then bay 2 requests with mode 4'b0010 → `Grant=4'b0100` in cycle 1, `CounterEnable=1` with `CounterInput=1` for 16 cycles, then RELEASE and regrant of bay 2.
- Bays 0, 1 and 3 request continuously, `RrPtr=0` → grant order 0, 1, 3, 0; each slice is 16 enabled cycles.
- Bay 1 with mode 4'b1010 drops `BayRequest` after 5 enabled cycles → `CounterEnable` falls the next cycle, and bay 2 (requesting) is granted next.
- Bay 0 with mode 4'b0111 and bay 1 with mode 4'b0010 → `ModeError=4'b0001` for 1 cycle, then bay 1 is granted with rate 1.
- `BayDone[3]` rises mid-slice → `CounterEnable=0` the next cycle, and bay 3 is not regranted while `BayDone[3]=1`.
- `ResetN` pulsed low in CHARGE → all outputs 0 immediately, and after release the first grant starts from bay 0.

Source files
------------

// File: rtl/charge_bay_scheduler_pkg.sv
// rtl/charge_bay_scheduler_pkg.sv - shared types, mode codes and mode-to-rate decode for the charge bay scheduler
//
// Package charge_pkg:
//   state_e      scheduler FSM state encoding (IDLE, GRANT, CHARGE, RELEASE)
//   MODE_*       bay mode codes understood by the scheduler
//   RATE_*       charge counter rate per cycle for each mode
//   mode_rate()  decodes a bay mode into a counter rate; 0 means invalid mode
package charge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_CHARGE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] MODE_NORMAL = 4'b0010;
  localparam logic [3:0] MODE_FAST   = 4'b1010;

  localparam logic [3:0] RATE_NORMAL = 4'd1;
  localparam logic [3:0] RATE_FAST   = 4'd5;

  // A rate of zero never occurs for a valid mode, so it doubles as the
  // "invalid mode" marker.
  function automatic logic [3:0] mode_rate(input logic [3:0] mode);
    logic [3:0] rate;
    case (mode)
      MODE_NORMAL: rate = RATE_NORMAL;
      MODE_FAST:   rate = RATE_FAST;
      default:     rate = 4'd0;
    endcase
    return rate;
  endfunction

endpackage

// File: rtl/charge_bay_scheduler_if.sv
// rtl/charge_bay_scheduler_if.sv - bay-side and counter-side signal bundle of the charge bay scheduler
//
// Interface charge_bay_if #(NUM_BAYS):
//   BayRequest    [NUM_BAYS]    bay b wants charge (level)
//   BayMode       [4*NUM_BAYS]  mode of bay b in bits [4b+3:4b]
//   BayDone       [NUM_BAYS]    bay b full / unplugged (level)
//   Grant         [NUM_BAYS]    one-hot granted bay
//   ActiveBay     [3]           index of granted bay, valid while Grant != 0
//   CounterEnable [1]           charge counter enable
//   CounterInput  [4]           counter rate per cycle
//   ModeError     [NUM_BAYS]    one-cycle pulse: bay skipped for invalid mode
// Modports: master = bay logic / counter side, slave = scheduler.
interface charge_bay_if #(
  parameter int NUM_BAYS = 4
);

  logic [NUM_BAYS-1:0]   BayRequest;
  logic [4*NUM_BAYS-1:0] BayMode;
  logic [NUM_BAYS-1:0]   BayDone;
  logic [NUM_BAYS-1:0]   Grant;
  logic [2:0]            ActiveBay;
  logic                  CounterEnable;
  logic [3:0]            CounterInput;
  logic [NUM_BAYS-1:0]   ModeError;

  modport master (
    output BayRequest, BayMode, BayDone,
    input  Grant, ActiveBay, CounterEnable, CounterInput, ModeError
  );

  modport slave (
    input  BayRequest, BayMode, BayDone,
    output Grant, ActiveBay, CounterEnable, CounterInput, ModeError
  );

endinterface

// File: rtl/charge_bay_scheduler_rr_picker.sv
// rtl/charge_bay_scheduler_rr_picker.sv - combinational round-robin priority encoder
//
// Module rr_picker #(N):
//   Eligible  in  [N]  candidate vector
//   RrPtr     in  [3]  first index to consider (must be < N)
//   Pick      out [N]  one-hot first eligible index at or after RrPtr, wrapping
//   PickIdx   out [3]  binary index of Pick
//   AnyValid  out [1]  Eligible has at least one bit set
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] Eligible,
  input  logic [2:0]   RrPtr,
  output logic [N-1:0] Pick,
  output logic [2:0]   PickIdx,
  output logic         AnyValid
);

  logic found;
  int   j;

  always_comb begin
    Pick     = '0;
    PickIdx  = '0;
    AnyValid = |Eligible;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(RrPtr) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!found && Eligible[j]) begin
        found    = 1'b1;
        Pick[j]  = 1'b1;
        PickIdx  = 3'(j);
      end
    end
  end

endmodule

// File: rtl/charge_bay_scheduler.sv
// rtl/charge_bay_scheduler.sv - round-robin time-slicing of the single charge counter among vehicle bays
//
// Module charge_bay_scheduler #(NUM_BAYS, SLICE_CYCLES):
//   Clock   in  rising-edge clock
//   ResetN  in  asynchronous active-low reset
//   bus     charge_bay_if.slave: bay requests/modes/done in; Grant, ActiveBay,
//           CounterEnable, CounterInput, ModeError out (all registered)
// Optional feature macro: CHARGE_FAST_PRIORITY_EN -- fast-mode bays are picked
// ahead of normal bays (round-robin within each class, shared pointer).
module charge_bay_scheduler
  import charge_pkg::*;
#(
  parameter int NUM_BAYS     = 4,
  parameter int SLICE_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        ResetN,
  charge_bay_if.slave bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] GRANT   = ST_GRANT;
  localparam logic [1:0] CHARGE  = ST_CHARGE;
  localparam logic [1:0] RELEASE = ST_RELEASE;

  localparam logic [11:0] SLICE_LAST = 12'(SLICE_CYCLES - 1);
  localparam logic [2:0]  LAST_BAY   = 3'(NUM_BAYS - 1);

  logic [1:0]          state;
  logic [2:0]          rr_ptr;
  logic [11:0]         slice_cnt;
  logic [3:0]          rate_q;
  logic [2:0]          granted_idx;
  logic [NUM_BAYS-1:0] grant_q;
  logic [2:0]          active_q;
  logic                cnt_en_q;
  logic [3:0]          cnt_in_q;
  logic [NUM_BAYS-1:0] mode_err_q;

  logic [NUM_BAYS-1:0] eligible;
  logic [NUM_BAYS-1:0] sel_pick;
  logic [2:0]          sel_idx;
  logic                sel_any;
  logic [3:0]          sel_mode;
  logic [3:0]          sel_rate;
  logic                slice_exit;

  function automatic logic [2:0] next_ptr(input logic [2:0] b);
    return (b == LAST_BAY) ? 3'd0 : b + 3'd1;
  endfunction

  assign eligible = bus.BayRequest & ~bus.BayDone;

`ifdef CHARGE_FAST_PRIORITY_EN
  logic [NUM_BAYS-1:0] fast_eligible;
  logic [NUM_BAYS-1:0] fast_pick;
  logic [2:0]          fast_idx;
  logic                fast_any;
  logic [NUM_BAYS-1:0] all_pick;
  logic [2:0]          all_idx;
  logic                all_any;

  always_comb begin
    fast_eligible = '0;
    for (int b = 0; b < NUM_BAYS; b++) begin
      fast_eligible[b] = eligible[b] && (bus.BayMode[4*b +: 4] == MODE_FAST);
    end
  end

  rr_picker #(.N(NUM_BAYS)) u_pick_fast (
    .Eligible (fast_eligible),
    .RrPtr    (rr_ptr),
    .Pick     (fast_pick),
    .PickIdx  (fast_idx),
    .AnyValid (fast_any)
  );

  rr_picker #(.N(NUM_BAYS)) u_pick_all (
    .Eligible (eligible),
    .RrPtr    (rr_ptr),
    .Pick     (all_pick),
    .PickIdx  (all_idx),
    .AnyValid (all_any)
  );

  // Any eligible fast bay wins over the plain round-robin choice.
  assign sel_pick = fast_any ? fast_pick : all_pick;
  assign sel_idx  = fast_any ? fast_idx  : all_idx;
  assign sel_any  = all_any;
`else
  rr_picker #(.N(NUM_BAYS)) u_pick_all (
    .Eligible (eligible),
    .RrPtr    (rr_ptr),
    .Pick     (sel_pick),
    .PickIdx  (sel_idx),
    .AnyValid (sel_any)
  );
`endif

  always_comb begin
    sel_mode = '0;
    for (int b = 0; b < NUM_BAYS; b++) begin
      if (sel_pick[b]) begin
        sel_mode = bus.BayMode[4*b +: 4];
      end
    end
  end

  assign sel_rate = mode_rate(sel_mode);

  // grant_q is one-hot on the granted bay, so masking avoids indexing with
  // a 3-bit bay number into a narrower vector.
  assign slice_exit = (slice_cnt == SLICE_LAST)
                   || ~|(bus.BayRequest & grant_q)
                   ||  |(bus.BayDone & grant_q);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      slice_cnt   <= '0;
      rate_q      <= '0;
      granted_idx <= '0;
      grant_q     <= '0;
      active_q    <= '0;
      cnt_en_q    <= 1'b0;
      cnt_in_q    <= '0;
      mode_err_q  <= '0;
    end else begin
      mode_err_q <= '0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            if (sel_rate != 4'd0) begin
              grant_q     <= sel_pick;
              active_q    <= sel_idx;
              granted_idx <= sel_idx;
              rate_q      <= sel_rate;
              state       <= GRANT;
            end else begin
              // Skip the bay for this turn; it is retried on its next turn.
              mode_err_q <= sel_pick;
              rr_ptr     <= next_ptr(sel_idx);
            end
          end
        end
        GRANT: begin
          slice_cnt <= '0;
          cnt_en_q  <= 1'b1;
          cnt_in_q  <= rate_q;
          state     <= CHARGE;
        end
        CHARGE: begin
          if (slice_exit) begin
            grant_q  <= '0;
            active_q <= '0;
            cnt_en_q <= 1'b0;
            cnt_in_q <= '0;
            state    <= RELEASE;
          end else begin
            slice_cnt <= slice_cnt + 12'd1;
          end
        end
        RELEASE: begin
          rr_ptr <= next_ptr(granted_idx);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Grant         = grant_q;
  assign bus.ActiveBay     = active_q;
  assign bus.CounterEnable = cnt_en_q;
  assign bus.CounterInput  = cnt_in_q;
  assign bus.ModeError     = mode_err_q;

endmodule

// File: tb/tb_charge_bay_scheduler.sv
// tb/tb_charge_bay_scheduler.sv - scoreboard testbench for charge_bay_scheduler
module tb_charge_bay_scheduler;

  localparam int NB = 4;
  localparam int S  = 16;

  typedef struct packed {
    logic [NB-1:0] grant;
    logic [2:0]    active;
    logic          ce;
    logic [3:0]    ci;
    logic [NB-1:0] merr;
  } exp_t;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  charge_bay_if #(.NUM_BAYS(NB)) bus ();

  charge_bay_scheduler #(.NUM_BAYS(NB), .SLICE_CYCLES(S)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  logic [NB-1:0] req;
  logic [NB-1:0] done;
  logic [3:0]    mode_v [NB];

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a slice is an owner bay plus its age in cycles since the
  // grant (age 0 = grant-only cycle, ages 1..S = enabled cycles).
  int   m_owner;
  int   m_age;
  int   m_ptr;
  int   m_rate;
  bit   m_rel;

  function automatic int rate_of(input logic [3:0] m);
    if (m == 4'b0010) return 1;
    if (m == 4'b1010) return 5;
    return 0;
  endfunction

  function automatic int pick_from(input logic [NB-1:0] elig);
    int b;
    for (int k = 0; k < NB; k++) begin
      b = (m_ptr + k) % NB;
      if (elig[b]) return b;
    end
    return -1;
  endfunction

  function automatic int model_pick();
    logic [NB-1:0] elig;
    logic [NB-1:0] fast;
    elig = req & ~done;
    fast = '0;
    for (int b = 0; b < NB; b++) fast[b] = elig[b] && (mode_v[b] == 4'b1010);
`ifdef CHARGE_FAST_PRIORITY_EN
    if (fast != '0) return pick_from(fast);
`endif
    return pick_from(elig);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_ptr   = 0;
    m_rate  = 0;
    m_rel   = 1'b0;
  endtask

  task automatic model_step(output exp_t e);
    int b;
    e = '0;
    if (m_rel) begin
      m_rel   = 1'b0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      b = model_pick();
      if (b >= 0) begin
        if (rate_of(mode_v[b]) == 0) begin
          e.merr[b] = 1'b1;
          m_ptr     = (b + 1) % NB;
        end else begin
          m_owner     = b;
          m_age       = 0;
          m_rate      = rate_of(mode_v[b]);
          e.grant[b]  = 1'b1;
          e.active    = 3'(b);
        end
      end
    end else if (m_age >= 1 && (m_age == S || !req[m_owner] || done[m_owner])) begin
      m_rel = 1'b1;
      m_ptr = (m_owner + 1) % NB;
    end else begin
      m_age            = m_age + 1;
      e.grant[m_owner] = 1'b1;
      e.active         = 3'(m_owner);
      e.ce             = 1'b1;
      e.ci             = 4'(m_rate);
    end
  endtask

  task automatic drive_inputs();
    bus.BayRequest = req;
    bus.BayDone    = done;
    for (int b = 0; b < NB; b++) bus.BayMode[4*b +: 4] = mode_v[b];
  endtask

  // One clock of stimulus: inputs change at the falling edge, the expected
  // outputs after the following rising edge are queued for the monitor.
  task automatic cycle(input logic rstn);
    exp_t e;
    @(negedge Clock);
    ResetN = rstn;
    drive_inputs();
    if (!rstn) begin
      model_reset();
      e = '0;
    end else begin
      model_step(e);
    end
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.Grant !== '0 || bus.ActiveBay !== '0 || bus.CounterEnable !== 1'b0
        || bus.CounterInput !== '0 || bus.ModeError !== '0) begin
      errors++;
      $display("FAIL %s actual grant=%b active=%0d ce=%b ci=%0d merr=%b required all zero",
               name, bus.Grant, bus.ActiveBay, bus.CounterEnable, bus.CounterInput, bus.ModeError);
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        a.grant  = bus.Grant;
        a.active = bus.ActiveBay;
        a.ce     = bus.CounterEnable;
        a.ci     = bus.CounterInput;
        a.merr   = bus.ModeError;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_out t=%0t actual grant=%b active=%0d ce=%b ci=%0d merr=%b required grant=%b active=%0d ce=%b ci=%0d merr=%b",
                   $time, a.grant, a.active, a.ce, a.ci, a.merr,
                   e.grant, e.active, e.ce, e.ci, e.merr);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    exp_t e;
    req  = '0;
    done = '0;
    for (int b = 0; b < NB; b++) mode_v[b] = 4'b0010;
    drive_inputs();
    model_reset();
    #2;
    check_zero("reset_state");
    repeat (3) cycle(1'b0);

    // Single bay 2, normal mode: two back-to-back slices.
    req = 4'b0100;
    repeat (45) cycle(1'b1);

    // Bays 0, 1, 3 continuously: order 0, 1, 3, 0.
    req = 4'b1011;
    repeat (4 * (S + 3) + 4) cycle(1'b1);
    req = '0;
    repeat (4) cycle(1'b1);

    // Fast bay 1 drops its request after a few enabled cycles; bay 2 waits.
    model_reset();
    repeat (2) cycle(1'b0);
    mode_v[1] = 4'b1010;
    req = 4'b0110;
    repeat (2 + 5) cycle(1'b1);
    req = 4'b0100;
    repeat (25) cycle(1'b1);
    req = '0;
    mode_v[1] = 4'b0010;
    repeat (4) cycle(1'b1);

    // Invalid mode on bay 0 is skipped with a ModeError pulse.
    model_reset();
    repeat (2) cycle(1'b0);
    mode_v[0] = 4'b0111;
    req = 4'b0011;
    repeat (30) cycle(1'b1);
    req = '0;
    mode_v[0] = 4'b0010;
    repeat (4) cycle(1'b1);

    // Bay 3 reports done mid-slice and is not regranted while done.
    req = 4'b1000;
    repeat (8) cycle(1'b1);
    done = 4'b1000;
    repeat (12) cycle(1'b1);
    done = '0;
    req = '0;
    repeat (4) cycle(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(19) == 0) req[b] = ~req[b];
        if (done[b]) begin
          if ($urandom_range(9) == 0) done[b] = 1'b0;
        end else if ($urandom_range(59) == 0) begin
          done[b] = 1'b1;
        end
        if ($urandom_range(29) == 0) begin
          case ($urandom_range(4))
            0, 1:    mode_v[b] = 4'b0010;
            2, 3:    mode_v[b] = 4'b1010;
            default: mode_v[b] = 4'($urandom_range(15));
          endcase
        end
      end
      cycle(1'b1);
    end

    // Reset in the middle of a charge slice.
    req  = 4'b0101;
    done = '0;
    for (int b = 0; b < NB; b++) mode_v[b] = 4'b0010;
    waited = 0;
    while (!(m_owner >= 0 && !m_rel && m_age >= 3) && waited < 100) begin
      cycle(1'b1);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL charge_wait actual no slice reached in %0d cycles required slice", waited);
    end
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    e = '0;
    exp_q.push_back(e);
    cycle(1'b0);
    repeat (30) cycle(1'b1);
    req = '0;
    repeat (6) cycle(1'b1);

    @(posedge Clock);
    #2;
    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(posedge Clock);
      #2;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
